// File: rtl/bist_pkg.sv
// Shared types and defaults for the response-side BIST stage.
// Holds the FSM state encoding and the MISR width/polynomial defaults.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

  localparam int BIST_WIDTH = 5;
  localparam logic [BIST_WIDTH-1:0] BIST_POLY = 5'b00101;

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register.
// Shifts left, folds the MSB back through POLY and XORs in d.
import bist_pkg::*;

module misr_reg #(
  parameter int WIDTH = BIST_WIDTH,
  parameter logic [WIDTH-1:0] POLY = BIST_POLY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] fb;

  assign fb = q[WIDTH-1] ? POLY : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], 1'b0} ^ fb ^ d;
    end
  end

endmodule

// File: rtl/bist_misr_checker.sv
// BIST response checker: paces the pattern generator, compacts
// responses into a MISR and compares the final signature.
import bist_pkg::*;

module bist_misr_checker #(
  parameter int WIDTH = BIST_WIDTH,
  parameter int NUM_PATTERNS = 31,
  parameter logic [WIDTH-1:0] POLY = BIST_POLY,
  parameter logic [WIDTH-1:0] GOLDEN_SIG = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] resp_in,
  input  logic             resp_valid,
  output logic             pattern_enb,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  localparam int CW = $clog2(NUM_PATTERNS + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS - 1);
  localparam logic [CW-1:0] NUM = CW'(NUM_PATTERNS);

  bist_state_t state, state_d;
  logic [CW-1:0] count;
  logic clr, upd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    clr = 1'b0;
    upd = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          clr = 1'b1;
        end
      end
      RUN: begin
        if (resp_valid) begin
          upd = 1'b1;
          if (count == LAST) state_d = CHECK;
        end
      end
      CHECK: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // count saturates at NUM_PATTERNS because RUN is left on that edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (upd) begin
      count <= count + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass <= 1'b0;
    end else if (clr) begin
      pass <= 1'b0;
    end else if (state == CHECK) begin
      pass <= (signature == GOLDEN_SIG);
    end
  end

  misr_reg #(
    .WIDTH(WIDTH),
    .POLY (POLY)
  ) u_misr (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .en   (upd),
    .d    (resp_in),
    .q    (signature)
  );

  assign pattern_enb = (state == RUN) && (count < NUM);
  assign busy = (state == RUN) || (state == CHECK);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bist_misr_checker.sv
// Directed bench for bist_misr_checker: three instances with
// different pattern counts / golden values share one stimulus.
import bist_pkg::*;

module tb_bist_misr_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [4:0] resp_in = '0;
  logic resp_valid = 1'b0;

  logic enb_a, busy_a, done_a, pass_a;
  logic enb_b, busy_b, done_b, pass_b;
  logic enb_c, busy_c, done_c, pass_c;
  logic [4:0] sig_a, sig_b, sig_c;

  int checks = 0;
  int errors = 0;
  logic [4:0] model;

  always #5 clk = ~clk;

  bist_misr_checker #(
    .WIDTH(5), .NUM_PATTERNS(3),
    .POLY(5'b00101), .GOLDEN_SIG(5'b00110)
  ) u_a (
    .clk(clk), .reset(reset), .start(start),
    .resp_in(resp_in), .resp_valid(resp_valid),
    .pattern_enb(enb_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .signature(sig_a)
  );

  bist_misr_checker #(
    .WIDTH(5), .NUM_PATTERNS(3),
    .POLY(5'b00101), .GOLDEN_SIG(5'b00111)
  ) u_b (
    .clk(clk), .reset(reset), .start(start),
    .resp_in(resp_in), .resp_valid(resp_valid),
    .pattern_enb(enb_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .signature(sig_b)
  );

  bist_misr_checker #(
    .WIDTH(5), .NUM_PATTERNS(31),
    .POLY(5'b00101), .GOLDEN_SIG(5'b00000)
  ) u_c (
    .clk(clk), .reset(reset), .start(start),
    .resp_in(resp_in), .resp_valid(resp_valid),
    .pattern_enb(enb_c), .busy(busy_c), .done(done_c),
    .pass(pass_c), .signature(sig_c)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] step(input logic [4:0] m,
                                      input logic [4:0] d);
    logic [4:0] r;
    r = {m[3:0], 1'b0} ^ d;
    if (m[4]) r = r ^ 5'b00101;
    return r;
  endfunction

  task automatic word(input logic [4:0] d);
    resp_valid = 1'b1;
    resp_in = d;
    tick();
  endtask

  initial begin
    logic [4:0] r;
    bit seen;

    // reset while idle
    tick();
    check("rst_enb", enb_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_sig", sig_a, 0);
    check("rst_state", u_a.state, IDLE);
    reset = 1'b0;
    tick();

    // basic 3-word run
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_enb", enb_a, 1);
    check("run_busy", busy_a, 1);
    check("run_sig0", sig_a, 0);
    word(5'b00001);
    check("sig1", sig_a, 5'b00001);
    word(5'b00001);
    check("sig2", sig_a, 5'b00011);
    word(5'b00000);
    resp_valid = 1'b0;
    check("sig3", sig_a, 5'b00110);
    check("chk_enb", enb_a, 0);
    check("chk_busy", busy_a, 1);
    check("chk_done", done_a, 0);
    tick();
    check("done_a", done_a, 1);
    check("pass_a", pass_a, 1);
    check("busy_a_off", busy_a, 0);
    check("done_b", done_b, 1);
    check("pass_b", pass_b, 0);
    check("sig_b", sig_b, 5'b00110);
    check("c_still_run", enb_c, 1);
    check("c_count", u_c.count, 3);

    // asynchronous reset in the middle of a run
    reset = 1'b1;
    #1;
    check("mid_rst_state", u_c.state, IDLE);
    check("mid_rst_enb", enb_c, 0);
    check("mid_rst_busy", busy_c, 0);
    check("mid_rst_sig", sig_c, 0);
    check("mid_rst_cnt", u_c.count, 0);
    tick();
    reset = 1'b0;
    tick();
    check("no_auto_run", busy_c, 0);

    // 31-word run: walk a one to the MSB, then exercise feedback
    start = 1'b1;
    tick();
    start = 1'b0;
    check("c_sig_clr", sig_c, 0);
    word(5'b00001);
    word(5'b00000);
    word(5'b00000);
    word(5'b00000);
    word(5'b00000);
    check("preload", sig_c, 5'b10000);
    check("a_sig_short", sig_a, 5'b00100);
    word(5'b00000);
    check("feedback", sig_c, 5'b00101);
    check("a_fail", pass_a, 0);
    model = 5'b00101;
    for (int i = 0; i < 25; i++) begin
      r = 5'($urandom_range(0, 31));
      model = step(model, r);
      word(r);
      check("rand_sig", sig_c, model);
    end
    resp_valid = 1'b0;
    check("c_enb_low", enb_c, 0);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      seen = done_c;
    end
    check("c_done_seen", seen, 1);
    check("c_pass", pass_c, model == 5'b00000);
    check("c_sig_hold", sig_c, model);

    // restart from DONE with gapped valid and stray starts
    start = 1'b1;
    tick();
    start = 1'b0;
    check("re_done_low", done_a, 0);
    check("re_pass_clr", pass_a, 0);
    check("re_sig_clr", sig_a, 0);
    check("re_enb", enb_a, 1);
    word(5'b00001);
    check("gap_cnt1", u_a.count, 1);
    resp_valid = 1'b0;
    resp_in = 5'b11111;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("gap_cnt1b", u_a.count, 1);
    check("gap_sig", sig_a, 5'b00001);
    check("gap_enb", enb_a, 1);
    tick();
    check("gap_cnt1c", u_a.count, 1);
    word(5'b00001);
    check("gap_cnt2", u_a.count, 2);
    resp_valid = 1'b0;
    tick();
    check("gap_enb2", enb_a, 1);
    word(5'b00000);
    resp_valid = 1'b0;
    check("gap_cnt3", u_a.count, 3);
    check("gap_enb_off", enb_a, 0);
    tick();
    check("gap_done", done_a, 1);
    check("gap_pass", pass_a, 1);
    check("gap_sig_end", sig_a, 5'b00110);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
